// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential/branch/JALR/trap redirect with stall and
// misaligned-target hold. Optional return-address stack enabled by PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] branch_offset,
    input  logic [XLEN-1:0] jump_base,
    input  logic [XLEN-1:0] jump_offset,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] target_s;
    logic            target_mis_s;

    assign pc_plus4   = pc_q + XLEN'(4);
    assign pc         = pc_q;
    assign misaligned = misaligned_q;

    // Redirect target; only branch and JALR can produce a misaligned address.
    always_comb begin
        target_s     = pc_plus4;
        target_mis_s = 1'b0;
        case (pc_sel)
            2'd0: target_s = pc_plus4;
            2'd1: begin
                target_s     = pc_q + branch_offset;
                target_mis_s = |target_s[1:0];
            end
            2'd2: begin
                target_s     = (jump_base + jump_offset) & ~{{(XLEN-1){1'b0}}, 1'b1};
                target_mis_s = |target_s[1:0];
            end
            2'd3: target_s = {trap_vector[XLEN-1:2], 2'b00};
            default: target_s = pc_plus4;
        endcase
    end

    // Next PC and flag: stalls and misaligned targets both hold the PC.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        if (stall) begin
            pc_d         = pc_q;
            misaligned_d = 1'b0;
        end else if (target_mis_s) begin
            pc_d         = pc_q;
            misaligned_d = 1'b1;
        end else begin
            pc_d         = target_s;
            misaligned_d = 1'b0;
        end
    end

    // PC and misaligned flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr_q, ras_ptr_d;
    logic [CW-1:0]   ras_cnt_q, ras_cnt_d;
    logic            ras_wr_s;
    logic [PW-1:0]   ras_idx_s;
    logic            ras_en_s;
    logic            ras_empty_s;

    assign ras_en_s    = !stall && !target_mis_s;
    assign ras_empty_s = (ras_cnt_q == CW'(0));

    // Stack pointer/count update; a push on a full stack overwrites the oldest slot.
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_wr_s  = 1'b0;
        ras_idx_s = ras_ptr_q;
        if (!ras_en_s) begin
            ras_wr_s = 1'b0;
        end else if (ras_push && ras_pop && !ras_empty_s) begin
            ras_wr_s = 1'b1;
        end else if (ras_push) begin
            ras_ptr_d = ras_ptr_q + PW'(1);
            ras_idx_s = ras_ptr_q + PW'(1);
            ras_wr_s  = 1'b1;
            if (ras_cnt_q != CW'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + CW'(1);
            end else begin
                ras_cnt_d = ras_cnt_q;
            end
        end else if (ras_pop && !ras_empty_s) begin
            ras_ptr_d = ras_ptr_q - PW'(1);
            ras_cnt_d = ras_cnt_q - CW'(1);
        end else begin
            ras_wr_s = 1'b0;
        end
    end

    // RAS storage and pointers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ras_ptr_q <= PW'(0);
            ras_cnt_q <= CW'(0);
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_wr_s) begin
                ras_mem_q[ras_idx_s] <= pc_plus4;
            end
        end
    end

    assign ras_top   = ras_empty_s ? {XLEN{1'b0}} : ras_mem_q[ras_ptr_q];
    assign ras_valid = !ras_empty_s;
`else
    logic unused_ras_s;
    assign unused_ras_s = ras_push ^ ras_pop;
    assign ras_top      = {XLEN{1'b0}};
    assign ras_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed plan steps plus random traffic against a
// queue-based reference model (RAS modelled only when PC_SEQUENCER_RAS_EN is defined).
module tb_pc_sequencer;
    localparam int          XLEN  = 32;
    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pc_sel = 2'd0;
    logic [31:0] branch_offset = 32'd0;
    logic [31:0] jump_base = 32'd0;
    logic [31:0] jump_offset = 32'd0;
    logic [31:0] trap_vector = 32'd0;
    logic        ras_push = 1'b0;
    logic        ras_pop = 1'b0;
    logic [31:0] pc, pc_plus4, ras_top;
    logic        misaligned, ras_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras[$];

    pc_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .pc_sel(pc_sel),
        .branch_offset(branch_offset), .jump_base(jump_base), .jump_offset(jump_offset),
        .trap_vector(trap_vector), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned),
        .ras_top(ras_top), .ras_valid(ras_valid)
    );

    always #5 clk = ~clk;

    task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_top;
        exp_top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0;
        cmp32({tag, ".pc"}, pc, m_pc);
        cmp32({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        cmp32({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, m_mis});
        cmp32({tag, ".ras_top"}, ras_top, exp_top);
        cmp32({tag, ".ras_valid"}, {31'd0, ras_valid}, {31'd0, m_ras.size() > 0});
    endtask

    // Drive one cycle, advance the reference model, then check after the edge.
    task automatic step(input string tag, input logic rst, input logic stl, input logic [1:0] sel,
                        input logic [31:0] bo, input logic [31:0] jb, input logic [31:0] jo,
                        input logic [31:0] tv, input logic psh, input logic pp);
        logic [31:0] t;
        logic        bad;
        reset_n = ~rst; stall = stl; pc_sel = sel; branch_offset = bo;
        jump_base = jb; jump_offset = jo; trap_vector = tv; ras_push = psh; ras_pop = pp;
        if (rst) begin
            m_pc = RV; m_mis = 1'b0; m_ras.delete();
        end else if (stl) begin
            m_mis = 1'b0;
        end else begin
            bad = 1'b0;
            case (sel)
                2'd0: t = m_pc + 32'd4;
                2'd1: begin t = m_pc + bo; bad = (t % 4) != 0; end
                2'd2: begin t = (jb + jo) & 32'hFFFF_FFFE; bad = (t % 4) != 0; end
                default: t = tv & 32'hFFFF_FFFC;
            endcase
            m_mis = bad;
            if (!bad) begin
`ifdef PC_SEQUENCER_RAS_EN
                if (psh && pp) begin
                    if (m_ras.size() == 0) m_ras.push_back(m_pc + 32'd4);
                    else m_ras[m_ras.size()-1] = m_pc + 32'd4;
                end else if (psh) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end else if (pp && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
`endif
                m_pc = t;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        m_pc = RV; m_mis = 1'b0;
        // Reset then sequential fetch.
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("seq", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Trap (low bits forced), backward branch, JALR with bit 0 cleared.
        step("trap200", 0, 0, 3, 0, 0, 0, 32'h203, 0, 0);
        step("branch_back", 0, 0, 1, 32'hFFFF_FFF0, 0, 0, 0, 0, 0);
        step("jalr", 0, 0, 2, 0, 32'h301, 32'h0, 0, 0, 0);
        // Stall with a pending branch, then release.
        for (int i = 0; i < 3; i++) step("stall", 0, 1, 1, 32'h40, 0, 0, 0, 1, 0);
        step("release", 0, 0, 1, 32'h40, 0, 0, 0, 0, 0);
        // Misaligned branch drops a concurrent push; flag lasts one cycle.
        step("trap10", 0, 0, 3, 0, 0, 0, 32'h10, 0, 0);
        step("mis_branch", 0, 0, 1, 32'h6, 0, 0, 0, 1, 0);
        step("mis_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mis_jalr", 0, 0, 2, 0, 32'h40, 32'h3, 0, 0, 1);
        // RAS fill past depth, drain, pop on empty.
        step("trap0", 0, 0, 3, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) step("push", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step("pop", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("pushpop_empty", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("pushpop", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Address wrap, then reset overriding push and trap.
        step("trap_top", 0, 0, 3, 0, 0, 0, 32'hFFFF_FFFC, 1, 0);
        step("wrap", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset_mid", 1, 1, 3, 0, 0, 0, 32'h400, 1, 0);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bo, jb, jo;
            bo = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00} - 32'h200;
            jb = $urandom;
            jo = $urandom_range(0, 15);
            step("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)), bo, jb, jo, $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised next-generation program counter for the fetch stage of the RISC-V core. Beyond sequential and PC-relative updates, it supports register-indirect jumps (JALR), trap redirection, pipeline stalls, misaligned-target detection, and an optional return-address stack (RAS) for call/return prediction. It sits between the control unit, which drives the select, stall and call/return hints, and the instruction memory, which it addresses.

## Interface
Parameters:
- `XLEN`, default 32: PC and datapath width.
- `RESET_VECTOR`, default 0: PC value after reset. Must be 4-byte aligned.
- `RAS_DEPTH`, default 4: RAS entry count. Must be ≥ 2 and a power of two.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `stall`  in  1: hold all state (PC, RAS, flag update suppressed).
- `pc_sel`  in  2: next-PC source. 0 = sequential, 1 = branch, 2 = jump register, 3 = trap.
- `branch_offset`  in  XLEN: signed offset for branch; target = `pc + branch_offset`.
- `jump_base`  in  XLEN: JALR base operand.
- `jump_offset`  in  XLEN: JALR offset; target = `(jump_base + jump_offset) & ~1`.
- `trap_vector`  in  XLEN: trap target; bits [1:0] forced to 0.
- `ras_push`  in  1: call hint; push `pc_plus4`.
- `ras_pop`  in  1: return hint; pop top entry.
- `pc`  out  XLEN: current PC (registered).
- `pc_plus4`  out  XLEN: `pc + 4` (combinational).
- `misaligned`  out  1: registered one-cycle flag; previous redirect target was misaligned.
- `ras_top`  out  XLEN: current top RAS entry (combinational from state); 0 when empty.
- `ras_valid`  out  1: RAS non-empty.

## Operation
- Update priority per edge: reset, then stall, then normal update.
- Normal update: compute target from `pc_sel`. All arithmetic is modulo 2^XLEN; wrap-around past the top of the address space is silent.
- Misaligned target: a branch or jump target with bits [1:0] ≠ 0.
  - `pc` holds its value.
  - `misaligned` = 1 for exactly the following cycle.
  - RAS push and pop are suppressed in that cycle.
- Sequential and trap targets are never misaligned.
- `misaligned` is 0 on every edge that is not a misaligned redirect, including stalled edges.
- RAS: circular buffer with a top pointer and a count (0..RAS_DEPTH). RAS ops apply only on non-stalled, non-misaligned edges.
  - Push: `ptr+1` mod depth, write `pc_plus4`, count saturates at RAS_DEPTH. When full, the oldest entry is silently overwritten.
  - Pop: when count > 0, `ptr-1` mod depth and count-1. When empty, no state change.
  - Push and pop together: overwrite the top entry with `pc_plus4`, count unchanged. If empty, this acts as a push.
- `ras_push`/`ras_pop` are independent of `pc_sel`.

## Timing
- Redirect latency: `pc` reflects the selected target on the first edge where `stall` = 0. `pc_plus4`, `ras_top` and `ras_valid` follow combinationally.
- Reset values: `pc` = RESET_VECTOR, `pc_plus4` = RESET_VECTOR+4, `misaligned` = 0, count = 0, ptr = 0, all entries 0, `ras_top` = 0, `ras_valid` = 0.
- Reset asserted mid-operation overrides stall and any pending redirect on that edge.
- No combinational path from any input to `pc` or `misaligned`.

## Configuration
- `PC_SEQUENCER_RAS_EN` defined: RAS storage, pointer and count are built as described above.
- Undefined:
  - No RAS storage is built.
  - `ras_push`/`ras_pop` are ignored.
  - `ras_top` is tied to 0 and `ras_valid` to 0.
  - All PC and misaligned behaviour is unchanged.

## Test plan
- Reset then 3 sequential edges with RESET_VECTOR = 0x100 → `pc` = 0x100, 0x104, 0x108, 0x10C.
- `pc` = 0x200, branch_offset = 0xFFFFFFF0 → `pc` = 0x1F0. Then jump with base = 0x301, offset = 0 → `pc` = 0x300.
- Stall held for 3 edges with `pc_sel` = 1 → `pc` is unchanged. Release stall → branch is taken on the next edge.
- branch_offset = 0x6 from `pc` = 0x10 → `pc` stays 0x10, `misaligned` = 1 for one cycle, and a concurrent `ras_push` is dropped (count unchanged).
- RAS_DEPTH = 4, push 5 times from PCs 0x0, 0x4, …, 0x10 → `ras_top` = 0x14, count = 4. Then 4 pops → tops 0x10, 0xC, 0x8, then empty (`ras_valid` = 0). A further pop leaves the state unchanged.
- `pc` = 0xFFFFFFFC sequential → `pc` = 0x0. Reset asserted during a push with a trap selected → all reset values are restored on that edge.
